// File: rtl/sb_pkg.sv
// Shared definitions for the programmable switch box: FSM states, the
// "unconnected" select code and the configuration-size helper.
package sb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2,
    OVER  = 2'd3
  } sb_state_e;

  localparam int SEL_OFF = 0;

  function automatic int cfg_bits(input int sides, input int w);
    return sides * w * $clog2(sides);
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One output track of the switch box: picks the same track index from the
// side that is 'sel' positions around from its own side, or drives 0.
module sb_track_mux
  import sb_pkg::*;
#(
  parameter int SIDES = 4
) (
  input  logic [SIDES-1:0]         trk_in,
  input  logic [$clog2(SIDES)-1:0] sel,
  input  logic [$clog2(SIDES)-1:0] side,
  output logic                     trk_out
);

  int src_side;

  always_comb begin
    trk_out  = 1'b0;
    src_side = (int'(side) + int'(sel)) % SIDES;
    // Codes at or beyond SIDES are unused and treated like SEL_OFF.
    if (int'(sel) != SEL_OFF && int'(sel) < SIDES) begin
      for (int k = 0; k < SIDES; k++) begin
        if (k == src_side) trk_out = trk_in[k];
      end
    end
  end

endmodule

// File: rtl/sb_prog_switch.sv
// Programmable switch box: serial shadow chain with a bit-count FSM, a
// commit-gated active register, and per-track routing muxes driven from it.
module sb_prog_switch
  import sb_pkg::*;
#(
  parameter int SIDES = 4,
  parameter int W     = 4
) (
  input  logic               rst,
  input  logic               prog_clk,
  input  logic [SIDES*W-1:0] in_bus,
  output logic [SIDES*W-1:0] out_bus,
  input  logic               prog_in,
  input  logic               prog_en,
  input  logic               commit,
  output logic               prog_out,
  output logic               cfg_valid,
  output logic               cfg_err
);

  localparam int SEL_W    = $clog2(SIDES);
  localparam int CFG_BITS = cfg_bits(SIDES, W);
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_ARMED = ARMED;
  localparam logic [1:0] S_OVER  = OVER;

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          state_q, state_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    valid_d  = valid_q;
    err_d    = err_q;
    // Commit wins over a simultaneous shift and is judged on the current state.
    if (commit) begin
      cnt_d   = '0;
      state_d = S_IDLE;
      if (state_q == S_ARMED) begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (prog_en) begin
      shadow_d = {prog_in, shadow_q[CFG_BITS-1:1]};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      case (state_q)
        S_IDLE, S_SHIFT: state_d = (cnt_d == CNT_FULL) ? S_ARMED : S_SHIFT;
        S_ARMED:         state_d = S_OVER;
        default:         state_d = S_OVER;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign prog_out  = shadow_q[0];
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  // Routing reads only the active register, so shifting never disturbs it.
  for (genvar s = 0; s < SIDES; s++) begin : g_side
    for (genvar t = 0; t < W; t++) begin : g_trk
      logic [SIDES-1:0] trk;
      for (genvar k = 0; k < SIDES; k++) begin : g_col
        assign trk[k] = in_bus[k*W+t];
      end
      sb_track_mux #(
        .SIDES(SIDES)
      ) u_mux (
        .trk_in (trk),
        .sel    (active_q[(s*W+t)*SEL_W +: SEL_W]),
        .side   (SEL_W'(s)),
        .trk_out(out_bus[s*W+t])
      );
    end
  end

endmodule

// File: tb/tb_sb_prog_switch.sv
// Directed bench for sb_prog_switch at default parameters (4 sides x 4 tracks).
module tb_sb_prog_switch;

  logic        rst;
  logic        prog_clk;
  logic [15:0] in_bus;
  logic [15:0] out_bus;
  logic        prog_in;
  logic        prog_en;
  logic        commit;
  logic        prog_out;
  logic        cfg_valid;
  logic        cfg_err;

  int nvec;
  int nerr;

  sb_prog_switch #(.SIDES(4), .W(4)) dut (
    .rst      (rst),
    .prog_clk (prog_clk),
    .in_bus   (in_bus),
    .out_bus  (out_bus),
    .prog_in  (prog_in),
    .prog_en  (prog_en),
    .commit   (commit),
    .prog_out (prog_out),
    .cfg_valid(cfg_valid),
    .cfg_err  (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Shift bits lo..hi of w, one per clock; outputs settle #1 after the edge.
  task automatic shift_bits(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      prog_en = 1'b1;
      prog_in = w[i%32];
      @(posedge prog_clk);
      #1;
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(posedge prog_clk);
    #1;
    commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    nvec++; if (out_bus !== 16'h0000) begin nerr++; $display("FAIL reset_out_bus got=%h exp=%h", out_bus, 16'h0000); end
    nvec++; if (prog_out !== 1'b0) begin nerr++; $display("FAIL reset_prog_out got=%b exp=0", prog_out); end
    nvec++; if (cfg_valid !== 1'b0) begin nerr++; $display("FAIL reset_cfg_valid got=%b exp=0", cfg_valid); end
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    @(posedge prog_clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_basic_route();
    shift_bits(32'h5555_5555, 0, 31);
    nvec++; if (out_bus !== 16'h0000) begin nerr++; $display("FAIL basic_precommit got=%h exp=%h", out_bus, 16'h0000); end
    do_commit();
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL basic_out_bus got=%h exp=%h", out_bus, 16'h1842); end
    nvec++; if (cfg_valid !== 1'b1) begin nerr++; $display("FAIL basic_cfg_valid got=%b exp=1", cfg_valid); end
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL basic_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_short_load();
    shift_bits(32'hAAAA_AAAA, 0, 30);
    do_commit();
    nvec++; if (cfg_err !== 1'b1) begin nerr++; $display("FAIL short_cfg_err got=%b exp=1", cfg_err); end
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL short_out_bus got=%h exp=%h", out_bus, 16'h1842); end
    nvec++; if (cfg_valid !== 1'b1) begin nerr++; $display("FAIL short_cfg_valid got=%b exp=1", cfg_valid); end
    // Count restarted from zero: a full load right after must be accepted.
    shift_bits(32'hAAAA_AAAA, 0, 31);
    do_commit();
    nvec++; if (out_bus !== 16'h2184) begin nerr++; $display("FAIL short_reload_out got=%h exp=%h", out_bus, 16'h2184); end
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL short_reload_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_long_load();
    shift_bits(32'h5555_5555, 0, 32);
    do_commit();
    nvec++; if (cfg_err !== 1'b1) begin nerr++; $display("FAIL long_cfg_err got=%b exp=1", cfg_err); end
    nvec++; if (out_bus !== 16'h2184) begin nerr++; $display("FAIL long_out_bus got=%h exp=%h", out_bus, 16'h2184); end
    shift_bits(32'h5555_5555, 0, 31);
    do_commit();
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL long_clear_err got=%b exp=0", cfg_err); end
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL long_reload_out got=%h exp=%h", out_bus, 16'h1842); end
  endtask

  task automatic test_reconfig_hold();
    shift_bits(32'hAAAA_AAAA, 0, 15);
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL hold_mid_out got=%h exp=%h", out_bus, 16'h1842); end
    in_bus = 16'h1248;
    #1;
    nvec++; if (out_bus !== 16'h8124) begin nerr++; $display("FAIL hold_mid_alt got=%h exp=%h", out_bus, 16'h8124); end
    in_bus = 16'h8421;
    shift_bits(32'hAAAA_AAAA, 16, 31);
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL hold_full_out got=%h exp=%h", out_bus, 16'h1842); end
    do_commit();
    nvec++; if (out_bus !== 16'h2184) begin nerr++; $display("FAIL hold_commit_out got=%h exp=%h", out_bus, 16'h2184); end
  endtask

  task automatic test_commit_with_shift();
    shift_bits(32'h5555_5555, 0, 31);
    commit  = 1'b1;
    prog_en = 1'b1;
    prog_in = 1'b1;
    @(posedge prog_clk);
    #1;
    commit  = 1'b0;
    prog_en = 1'b0;
    prog_in = 1'b0;
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL same_cycle_out got=%h exp=%h", out_bus, 16'h1842); end
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL same_cycle_err got=%b exp=0", cfg_err); end
    // Unshifted shadow still has bit0 of 0x55555555 (=1) at the tail.
    nvec++; if (prog_out !== 1'b1) begin nerr++; $display("FAIL same_cycle_noshift got=%b exp=1", prog_out); end
  endtask

  task automatic test_readback();
    logic [31:0] w;
    w = 32'h1234_5678;
    shift_bits(w, 0, 31);
    for (int i = 0; i < 32; i++) begin
      nvec++;
      if (prog_out !== w[i]) begin
        nerr++;
        $display("FAIL readback_bit%0d got=%b exp=%b", i, prog_out, w[i]);
      end
      shift_bits(32'h0, 0, 0);
    end
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL readback_out got=%h exp=%h", out_bus, 16'h1842); end
  endtask

  task automatic test_reset_mid_shift();
    shift_bits(32'hFFFF_FFFF, 0, 9);
    rst = 1'b0;
    #2;
    nvec++; if (out_bus !== 16'h0000) begin nerr++; $display("FAIL midrst_out got=%h exp=%h", out_bus, 16'h0000); end
    nvec++; if (cfg_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid got=%b exp=0", cfg_valid); end
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL midrst_err got=%b exp=0", cfg_err); end
    nvec++; if (prog_out !== 1'b0) begin nerr++; $display("FAIL midrst_prog_out got=%b exp=0", prog_out); end
    @(posedge prog_clk);
    #1;
    rst = 1'b1;
    // A full load starting on the very first edge must be accepted.
    shift_bits(32'h5555_5555, 0, 31);
    nvec++; if (prog_out !== 1'b1) begin nerr++; $display("FAIL midrst_first_bit got=%b exp=1", prog_out); end
    do_commit();
    nvec++; if (out_bus !== 16'h1842) begin nerr++; $display("FAIL midrst_reload_out got=%h exp=%h", out_bus, 16'h1842); end
    nvec++; if (cfg_valid !== 1'b1) begin nerr++; $display("FAIL midrst_reload_valid got=%b exp=1", cfg_valid); end
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    rst     = 1'b0;
    in_bus  = 16'h8421;
    prog_in = 1'b0;
    prog_en = 1'b0;
    commit  = 1'b0;
    test_reset();
    test_basic_route();
    test_short_load();
    test_long_load();
    test_reconfig_hold();
    test_commit_with_shift();
    test_readback();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
